// File: rtl/sw_debounce_pkg.sv
// rtl/sw_debounce_pkg.sv - shared board constants and counter sizing helper
// Purpose: board-level constants shared by the switch conditioning logic.
// Ports: none (package).
package sw_debounce_pkg;

  localparam int CLK_HZ           = 50_000_000;
  localparam int SW_DEBOUNCE_10MS = 500000;
  localparam int SW_WIDTH         = 8;

  // Counter width that holds 0..cycles-1, never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/sw_debounce_if.sv
// rtl/sw_debounce_if.sv - switch conditioning signal bundle
// Purpose: groups raw switch input and conditioned outputs.
// Ports: sw_raw (raw pins), sw_clean (debounced level), sw_rise/sw_fall
//        (per-bit edge pulses), sw_changed (any-edge pulse).
//        master = switch source / consumer side, slave = debouncer.
interface sw_debounce_if
  import sw_debounce_pkg::*;
#(
  parameter int WIDTH = SW_WIDTH
);

  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_clean;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic             sw_changed;

  modport master (
    output sw_raw,
    input  sw_clean,
    input  sw_rise,
    input  sw_fall,
    input  sw_changed
  );

  modport slave (
    input  sw_raw,
    output sw_clean,
    output sw_rise,
    output sw_fall,
    output sw_changed
  );

endinterface

// File: rtl/sw_debounce_bit.sv
// rtl/sw_debounce_bit.sv - one-bit synchroniser, stability counter and edge flops
// Purpose: conditions a single raw switch bit.
// Ports: clk, reset_n (async, active-low), raw (asynchronous pin),
//        clean (debounced level), rise/fall (registered one-cycle pulses),
//        rise_next/fall_next (combinational terms feeding rise/fall, used
//        by the parent to build a coincident any-change flag).
module sw_debounce_bit
  import sw_debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_10MS
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall,
  output logic rise_next,
  output logic fall_next
);

  localparam int                 CNT_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0]       cnt;
  logic                   s;
  logic                   accept;

  assign s = sync[SYNC_STAGES-1];

  // Accept only when the disagreement has lasted the full window.
  always_comb begin
    accept    = (s != clean) && (cnt == CNT_MAX);
    rise_next = accept & s;
    fall_next = accept & ~s;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync  <= '0;
      cnt   <= '0;
      clean <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
      rise <= rise_next;
      fall <= fall_next;
      // Agreement with the clean level (a glitch ending) restarts the count.
      if (s == clean) begin
        cnt <= '0;
      end else if (accept) begin
        clean <= s;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - slide switch synchroniser and debouncer
// Purpose: per-bit synchronise and debounce the slide switches, producing a
//          clean level for the PIO and rise/fall/any-change pulses.
// Ports: clk, reset_n (async, active-low), sw (sw_debounce_if.slave:
//        sw_raw in, sw_clean/sw_rise/sw_fall/sw_changed out).
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int WIDTH           = SW_WIDTH,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_10MS
) (
  input  logic         clk,
  input  logic         reset_n,
  sw_debounce_if.slave sw
);

  generate
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("sw_debounce: SYNC_STAGES must be 2 or more");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
      $error("sw_debounce: DEBOUNCE_CYCLES must be 1 or more");
    end
  endgenerate

  logic [WIDTH-1:0] clean_v;
  logic [WIDTH-1:0] rise_v;
  logic [WIDTH-1:0] fall_v;
  logic [WIDTH-1:0] rise_next_v;
  logic [WIDTH-1:0] fall_next_v;
  logic             changed_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sw_debounce_bit #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_bit (
      .clk       (clk),
      .reset_n   (reset_n),
      .raw       (sw.sw_raw[i]),
      .clean     (clean_v[i]),
      .rise      (rise_v[i]),
      .fall      (fall_v[i]),
      .rise_next (rise_next_v[i]),
      .fall_next (fall_next_v[i])
    );
  end

  // Registered from the same terms as the edge flops so it lines up with them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      changed_q <= 1'b0;
    end else begin
      changed_q <= |(rise_next_v | fall_next_v);
    end
  end

  assign sw.sw_clean   = clean_v;
  assign sw.sw_rise    = rise_v;
  assign sw.sw_fall    = fall_v;
  assign sw.sw_changed = changed_q;

endmodule

// File: tb/tb_sw_debounce.sv
// tb/tb_sw_debounce.sv - testbench for sw_debounce
module tb_sw_debounce;

  localparam int SS = 2;
  localparam int DC = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  int checks = 0;
  int failures = 0;

  sw_debounce_if #(.WIDTH(8)) bus ();

  sw_debounce #(
    .WIDTH           (8),
    .SYNC_STAGES     (SS),
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .sw      (bus)
  );

  always #5 clk = ~clk;

  // Reference model: the value the debouncer sees on an edge is the raw value
  // sampled SS edges earlier; a bit flips once the last DC seen values all
  // differ from its current clean level.
  logic [7:0] raw_hist[$];
  logic [7:0] seen_hist[$];
  logic [7:0] m_clean, m_rise, m_fall;
  logic       m_chg;

  function automatic void model_clear();
    raw_hist.delete();
    seen_hist.delete();
    m_clean = '0;
    m_rise  = '0;
    m_fall  = '0;
    m_chg   = 1'b0;
  endfunction

  function automatic void model_edge(input logic [7:0] raw);
    logic [7:0] seen;
    logic [7:0] acc;
    bit         all_diff;
    if (!reset_n) begin
      model_clear();
      return;
    end
    seen = (raw_hist.size() >= SS) ? raw_hist[raw_hist.size() - SS] : 8'h00;
    raw_hist.push_back(raw);
    seen_hist.push_back(seen);
    if (raw_hist.size() > 16) void'(raw_hist.pop_front());
    if (seen_hist.size() > 16) void'(seen_hist.pop_front());
    acc = '0;
    if (seen_hist.size() >= DC) begin
      for (int b = 0; b < 8; b++) begin
        all_diff = 1'b1;
        for (int j = 0; j < DC; j++)
          if (seen_hist[seen_hist.size() - 1 - j][b] == m_clean[b]) all_diff = 1'b0;
        acc[b] = all_diff;
      end
    end
    m_rise  = acc & seen;
    m_fall  = acc & ~seen;
    m_chg   = |acc;
    m_clean = m_clean ^ acc;
  endfunction

  task automatic cycle(input logic [7:0] raw);
    bus.sw_raw = raw;
    @(posedge clk);
    model_edge(raw);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    model_clear();
    for (int i = 0; i < 3; i++) begin
      cycle(8'hFF);
      checks++;
      if ({bus.sw_clean, bus.sw_rise, bus.sw_fall, bus.sw_changed} !== 25'h0) begin
        failures++;
        $display("FAIL reset_hold: got clean=%h rise=%h fall=%h chg=%b want all 0",
                 bus.sw_clean, bus.sw_rise, bus.sw_fall, bus.sw_changed);
      end
    end
    reset_n = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      cycle(8'hFF);
      checks++;
      if ({bus.sw_clean, bus.sw_rise, bus.sw_fall, bus.sw_changed} !== {m_clean, m_rise, m_fall, m_chg}) begin
        failures++;
        $display("FAIL reset_model: cyc=%0d got clean=%h rise=%h fall=%h chg=%b want clean=%h rise=%h fall=%h chg=%b",
                 i, bus.sw_clean, bus.sw_rise, bus.sw_fall, bus.sw_changed, m_clean, m_rise, m_fall, m_chg);
      end
      if (i == 5) begin
        checks++;
        if (bus.sw_clean !== 8'h00) begin
          failures++;
          $display("FAIL reset_early: got clean=%h want 00", bus.sw_clean);
        end
      end
      if (i == 6) begin
        checks++;
        if (bus.sw_clean !== 8'hFF || bus.sw_rise !== 8'hFF || bus.sw_changed !== 1'b1) begin
          failures++;
          $display("FAIL reset_accept: got clean=%h rise=%h chg=%b want FF FF 1",
                   bus.sw_clean, bus.sw_rise, bus.sw_changed);
        end
      end
      if (i == 7) begin
        checks++;
        if (bus.sw_rise !== 8'h00 || bus.sw_changed !== 1'b0) begin
          failures++;
          $display("FAIL reset_pulse_width: got rise=%h chg=%b want 00 0", bus.sw_rise, bus.sw_changed);
        end
      end
    end
  endtask

  task automatic test_clean_rise();
    for (int i = 1; i <= 16; i++) begin
      cycle(i <= 8 ? 8'h00 : 8'h01);
      checks++;
      if ({bus.sw_clean, bus.sw_rise, bus.sw_fall, bus.sw_changed} !== {m_clean, m_rise, m_fall, m_chg}) begin
        failures++;
        $display("FAIL rise_model: cyc=%0d got clean=%h rise=%h fall=%h chg=%b want clean=%h rise=%h fall=%h chg=%b",
                 i, bus.sw_clean, bus.sw_rise, bus.sw_fall, bus.sw_changed, m_clean, m_rise, m_fall, m_chg);
      end
      if (i == 13) begin
        checks++;
        if (bus.sw_clean !== 8'h00) begin
          failures++;
          $display("FAIL rise_early: got clean=%h want 00", bus.sw_clean);
        end
      end
      if (i == 14) begin
        checks++;
        if (bus.sw_clean !== 8'h01 || bus.sw_rise !== 8'h01 || bus.sw_changed !== 1'b1) begin
          failures++;
          $display("FAIL rise_accept: got clean=%h rise=%h chg=%b want 01 01 1",
                   bus.sw_clean, bus.sw_rise, bus.sw_changed);
        end
      end
      if (i == 15) begin
        checks++;
        if (bus.sw_rise !== 8'h00 || bus.sw_changed !== 1'b0) begin
          failures++;
          $display("FAIL rise_pulse_width: got rise=%h chg=%b want 00 0", bus.sw_rise, bus.sw_changed);
        end
      end
    end
  endtask

  task automatic test_glitch();
    for (int i = 0; i < 12; i++) begin
      cycle(i < 3 ? 8'h09 : 8'h01);
      checks++;
      if (bus.sw_clean !== 8'h01 || bus.sw_rise !== 8'h00 || bus.sw_fall !== 8'h00 || bus.sw_changed !== 1'b0) begin
        failures++;
        $display("FAIL glitch: cyc=%0d got clean=%h rise=%h fall=%h chg=%b want 01 00 00 0",
                 i, bus.sw_clean, bus.sw_rise, bus.sw_fall, bus.sw_changed);
      end
    end
  endtask

  task automatic test_bounce();
    logic [7:0] pat;
    pat = 8'b1111_0111;
    for (int i = 0; i < 12; i++) begin
      cycle(8'h01 | ((i < 8 ? {7'b0, pat[i]} : 8'h01) << 5));
      checks++;
      if ({bus.sw_clean, bus.sw_rise, bus.sw_fall, bus.sw_changed} !== {m_clean, m_rise, m_fall, m_chg}) begin
        failures++;
        $display("FAIL bounce_model: cyc=%0d got clean=%h rise=%h fall=%h chg=%b want clean=%h rise=%h fall=%h chg=%b",
                 i, bus.sw_clean, bus.sw_rise, bus.sw_fall, bus.sw_changed, m_clean, m_rise, m_fall, m_chg);
      end
      if (i == 8) begin
        checks++;
        if (bus.sw_clean[5] !== 1'b0) begin
          failures++;
          $display("FAIL bounce_early: got clean5=%b want 0", bus.sw_clean[5]);
        end
      end
      if (i == 9) begin
        checks++;
        if (bus.sw_clean[5] !== 1'b1 || bus.sw_rise !== 8'h20) begin
          failures++;
          $display("FAIL bounce_accept: got clean5=%b rise=%h want 1 20", bus.sw_clean[5], bus.sw_rise);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] raw;
    for (int i = 0; i < 24; i++) begin
      raw = (i < 8) ? 8'h00 : (i < 16) ? 8'hA5 : 8'h5A;
      cycle(raw);
      checks++;
      if ({bus.sw_clean, bus.sw_rise, bus.sw_fall, bus.sw_changed} !== {m_clean, m_rise, m_fall, m_chg}) begin
        failures++;
        $display("FAIL simul_model: cyc=%0d got clean=%h rise=%h fall=%h chg=%b want clean=%h rise=%h fall=%h chg=%b",
                 i, bus.sw_clean, bus.sw_rise, bus.sw_fall, bus.sw_changed, m_clean, m_rise, m_fall, m_chg);
      end
      if (i == 13) begin
        checks++;
        if (bus.sw_rise !== 8'hA5 || bus.sw_fall !== 8'h00 || bus.sw_changed !== 1'b1) begin
          failures++;
          $display("FAIL simul_up: got rise=%h fall=%h chg=%b want A5 00 1",
                   bus.sw_rise, bus.sw_fall, bus.sw_changed);
        end
      end
      if (i == 21) begin
        checks++;
        if (bus.sw_rise !== 8'h5A || bus.sw_fall !== 8'hA5 || bus.sw_changed !== 1'b1) begin
          failures++;
          $display("FAIL simul_swap: got rise=%h fall=%h chg=%b want 5A A5 1",
                   bus.sw_rise, bus.sw_fall, bus.sw_changed);
        end
      end
      if (i == 22) begin
        checks++;
        if (bus.sw_changed !== 1'b0 || bus.sw_clean !== 8'h5A) begin
          failures++;
          $display("FAIL simul_after: got chg=%b clean=%h want 0 5A", bus.sw_changed, bus.sw_clean);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 8; i++) cycle(8'h00);
    for (int i = 0; i < 4; i++) cycle(8'h01);
    reset_n = 1'b0;
    model_clear();
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (bus.sw_clean !== 8'h00 || bus.sw_changed !== 1'b0) begin
        failures++;
        $display("FAIL midreset_hold: got clean=%h chg=%b want 00 0", bus.sw_clean, bus.sw_changed);
      end
      cycle(8'h01);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle(8'h01);
      checks++;
      if ({bus.sw_clean, bus.sw_rise, bus.sw_fall, bus.sw_changed} !== {m_clean, m_rise, m_fall, m_chg}) begin
        failures++;
        $display("FAIL midreset_model: cyc=%0d got clean=%h rise=%h fall=%h chg=%b want clean=%h rise=%h fall=%h chg=%b",
                 i, bus.sw_clean, bus.sw_rise, bus.sw_fall, bus.sw_changed, m_clean, m_rise, m_fall, m_chg);
      end
      checks++;
      if (bus.sw_clean[0] !== (i >= 5)) begin
        failures++;
        $display("FAIL midreset_latency: cyc=%0d got clean0=%b want %b", i, bus.sw_clean[0], (i >= 5));
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] raw;
    raw = 8'h01;
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < 8; b++)
        if ($urandom_range(0, 5) == 0) raw[b] = ~raw[b];
      cycle(raw);
      checks++;
      if ({bus.sw_clean, bus.sw_rise, bus.sw_fall, bus.sw_changed} !== {m_clean, m_rise, m_fall, m_chg}) begin
        failures++;
        $display("FAIL random_model: cyc=%0d got clean=%h rise=%h fall=%h chg=%b want clean=%h rise=%h fall=%h chg=%b",
                 i, bus.sw_clean, bus.sw_rise, bus.sw_fall, bus.sw_changed, m_clean, m_rise, m_fall, m_chg);
      end
      checks++;
      if ((bus.sw_rise & bus.sw_fall) !== 8'h00) begin
        failures++;
        $display("FAIL random_rise_fall_overlap: got %h want 00", bus.sw_rise & bus.sw_fall);
      end
    end
  endtask

  initial begin
    bus.sw_raw = 8'hFF;
    model_clear();
    test_reset();
    test_clean_rise();
    test_glitch();
    test_bounce();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
